// File: rtl/thor2021_ptw_pkg.sv
// Shared types for the Thor2021 MMU: TLB entry layout, page-table entry layout,
// walker states and fault cause codes.
package Thor2021_pkg;

    typedef struct packed {
        logic [17:0] rsvd;
        logic [7:0]  asid;
        logic [9:0]  vpn;
        logic [19:0] ppn;
        logic        g;
        logic        d;
        logic        a;
        logic        u;
        logic        c;
        logic        r;
        logic        w;
        logic        x;
    } TLBEntry;

    typedef struct packed {
        logic [31:0] rsvd;
        logic [19:0] ppn;
        logic [2:0]  sw;
        logic        g;
        logic        d;
        logic        a;
        logic        u;
        logic        c;
        logic        r;
        logic        w;
        logic        x;
        logic        v;
    } PTE;

    typedef enum logic [2:0] {
        PTW_IDLE,
        PTW_L1,
        PTW_L2,
        PTW_WR,
        PTW_DONE,
        PTW_FAULT
    } ptw_state_t;

    localparam logic [1:0] PTW_FC_L1INV  = 2'd1;
    localparam logic [1:0] PTW_FC_L2INV  = 2'd2;
    localparam logic [1:0] PTW_FC_L1LEAF = 2'd3;

    // Tables are 1024 x 8 B and 8 kB aligned, so an entry address is base:index:000.
    function automatic logic [31:0] ptw_pt_addr(input logic [18:0] base, input logic [9:0] idx);
        return {base, idx, 3'b000};
    endfunction

endpackage

// File: rtl/thor2021_ptw_l1cache.sv
// One-entry cache of the last non-leaf L1 PTE, used by thor2021_ptw when
// THOR2021_PTW_L1CACHE_EN is defined.
module thor2021_ptw_l1cache (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [18:0] ptbr_base_i,
    input  logic [9:0]  lookup_idx_i,
    output logic        hit_o,
    output logic [18:0] hit_base_o,
    input  logic        fill_i,
    input  logic [9:0]  fill_idx_i,
    input  logic [18:0] fill_base_i
);

    logic        valid_q;
    logic [18:0] tag_ptbr_q;
    logic [9:0]  tag_idx_q;
    logic [18:0] base_q;
    logic [18:0] ptbr_prev_q;
    logic        ptbr_changed;

    assign ptbr_changed = (ptbr_base_i != ptbr_prev_q);

    // Any change of the table base makes the cached entry meaningless, even if
    // the base later returns to its old value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            tag_ptbr_q  <= '0;
            tag_idx_q   <= '0;
            base_q      <= '0;
            ptbr_prev_q <= '0;
        end else begin
            ptbr_prev_q <= ptbr_base_i;
            if (flush_i || ptbr_changed) begin
                valid_q <= 1'b0;
            end else if (fill_i) begin
                valid_q    <= 1'b1;
                tag_ptbr_q <= ptbr_base_i;
                tag_idx_q  <= fill_idx_i;
                base_q     <= fill_base_i;
            end
        end
    end

    assign hit_o = valid_q && !ptbr_changed
                && (tag_ptbr_q == ptbr_base_i)
                && (tag_idx_q == lookup_idx_i);
    assign hit_base_o = base_q;

endmodule

// File: rtl/thor2021_ptw.sv
// Two-level hardware page-table walker feeding the TLB update port.
// Optional one-entry L1 PTE cache enabled by defining THOR2021_PTW_L1CACHE_EN.
module thor2021_ptw
    import Thor2021_pkg::*;
#(
    parameter int AWID  = 32,
    parameter int ASIDW = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             miss_i,
    input  logic [AWID-1:0]  miss_adr_i,
    input  logic [ASIDW-1:0] asid_i,
    input  logic [AWID-1:0]  ptbr_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             fault_o,
    output logic [1:0]       fault_cause_o,
    output logic             cyc_o,
    output logic             stb_o,
    input  logic             ack_i,
    output logic [AWID-1:0]  adr_o,
    input  logic [63:0]      dat_i,
    output logic             wrtlb_o,
    output logic [15:0]      tlbadr_o,
    output logic [63:0]      tlbdat_o
);

    ptw_state_t       state_q;
    ptw_state_t       state_nxt;
    logic             rearm_q;
    logic [19:0]      va_q;
    logic [ASIDW-1:0] asid_q;
    logic [18:0]      l1_base_q;
    logic [19:0]      l2_ppn_q;
    logic [7:0]       l2_flags_q;
    logic [1:0]       cause_q;
    PTE               pte_in;
    TLBEntry          tlb_entry;
    logic             accept;
    logic             l1_hit;
    logic [18:0]      l1_hit_base;
    logic             unused_bits;

    assign pte_in      = dat_i;
    assign accept      = miss_i && rearm_q;
    assign unused_bits = ^{pte_in.rsvd, pte_in.sw, ptbr_i[12:0], miss_adr_i[11:0]};

`ifdef THOR2021_PTW_L1CACHE_EN
    logic l1_fill;

    assign l1_fill = (state_q == PTW_L1) && ack_i && pte_in.v
                  && !(pte_in.r || pte_in.w || pte_in.x);

    thor2021_ptw_l1cache u_l1cache (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .ptbr_base_i  (ptbr_i[31:13]),
        .lookup_idx_i (miss_adr_i[31:22]),
        .hit_o        (l1_hit),
        .hit_base_o   (l1_hit_base),
        .fill_i       (l1_fill),
        .fill_idx_i   (va_q[19:10]),
        .fill_base_i  (pte_in.ppn[19:1])
    );
`else
    assign l1_hit      = 1'b0;
    assign l1_hit_base = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PTW_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            PTW_IDLE:  if (accept) state_nxt = l1_hit ? PTW_L2 : PTW_L1;
            PTW_L1: begin
                if (ack_i) begin
                    if (!pte_in.v || pte_in.r || pte_in.w || pte_in.x) state_nxt = PTW_FAULT;
                    else                                                 state_nxt = PTW_L2;
                end
            end
            PTW_L2:    if (ack_i) state_nxt = pte_in.v ? PTW_WR : PTW_FAULT;
            PTW_WR:    state_nxt = PTW_DONE;
            PTW_DONE:  state_nxt = PTW_IDLE;
            PTW_FAULT: state_nxt = PTW_IDLE;
            default:   state_nxt = PTW_IDLE;
        endcase
    end

    // rearm only comes back after an idle cycle with miss_i low, so a miss the
    // TLB has not yet dropped is not walked twice.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rearm_q    <= 1'b1;
            va_q       <= '0;
            asid_q     <= '0;
            l1_base_q  <= '0;
            l2_ppn_q   <= '0;
            l2_flags_q <= '0;
            cause_q    <= '0;
        end else begin
            case (state_q)
                PTW_IDLE: begin
                    if (!miss_i) begin
                        rearm_q <= 1'b1;
                    end else if (rearm_q) begin
                        rearm_q <= 1'b0;
                        va_q    <= miss_adr_i[31:12];
                        asid_q  <= asid_i;
                        if (l1_hit) l1_base_q <= l1_hit_base;
                    end
                end
                PTW_L1: begin
                    if (ack_i) begin
                        l1_base_q <= pte_in.ppn[19:1];
                        if (!pte_in.v)                                cause_q <= PTW_FC_L1INV;
                        else if (pte_in.r || pte_in.w || pte_in.x)    cause_q <= PTW_FC_L1LEAF;
                    end
                end
                PTW_L2: begin
                    if (ack_i) begin
                        l2_ppn_q   <= pte_in.ppn;
                        l2_flags_q <= {pte_in.g, pte_in.d, pte_in.a, pte_in.u,
                                       pte_in.c, pte_in.r, pte_in.w, pte_in.x};
                        if (!pte_in.v) cause_q <= PTW_FC_L2INV;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_o        = (state_q != PTW_IDLE);
        cyc_o         = 1'b0;
        stb_o         = 1'b0;
        adr_o         = '0;
        wrtlb_o       = 1'b0;
        tlbadr_o      = '0;
        tlb_entry     = '0;
        done_o        = 1'b0;
        fault_o       = 1'b0;
        fault_cause_o = '0;
        case (state_q)
            PTW_L1: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                adr_o = ptw_pt_addr(ptbr_i[31:13], va_q[19:10]);
            end
            PTW_L2: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                adr_o = ptw_pt_addr(l1_base_q, va_q[9:0]);
            end
            PTW_WR: begin
                // Bit 15 of the TLB address selects the random way.
                wrtlb_o        = 1'b1;
                tlbadr_o       = {1'b1, 3'b000, 2'b00, va_q[9:0]};
                tlb_entry.asid = asid_q;
                tlb_entry.vpn  = va_q[19:10];
                tlb_entry.ppn  = l2_ppn_q;
                {tlb_entry.g, tlb_entry.d, tlb_entry.a, tlb_entry.u,
                 tlb_entry.c, tlb_entry.r, tlb_entry.w, tlb_entry.x} = l2_flags_q;
            end
            PTW_DONE:  done_o = 1'b1;
            PTW_FAULT: begin
                fault_o       = 1'b1;
                fault_cause_o = cause_q;
            end
            default: ;
        endcase
    end

    assign tlbdat_o = tlb_entry;

endmodule

// File: tb/tb_thor2021_ptw.sv
// Directed self-checking bench for thor2021_ptw with a small bus memory model;
// the L1-cache checks are built when THOR2021_PTW_L1CACHE_EN is defined.
module tb_thor2021_ptw;
    import Thor2021_pkg::*;

    logic        clk;
    logic        rst_i;
    logic        miss_i;
    logic [31:0] miss_adr_i;
    logic [7:0]  asid_i;
    logic [31:0] ptbr_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;
    logic        cyc_o;
    logic        stb_o;
    logic        ack_i;
    logic [31:0] adr_o;
    logic [63:0] dat_i;
    logic        wrtlb_o;
    logic [15:0] tlbadr_o;
    logic [63:0] tlbdat_o;

    thor2021_ptw dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .miss_i        (miss_i),
        .miss_adr_i    (miss_adr_i),
        .asid_i        (asid_i),
        .ptbr_i        (ptbr_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o),
        .cyc_o         (cyc_o),
        .stb_o         (stb_o),
        .ack_i         (ack_i),
        .adr_o         (adr_o),
        .dat_i         (dat_i),
        .wrtlb_o       (wrtlb_o),
        .tlbadr_o      (tlbadr_o),
        .tlbdat_o      (tlbdat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] mem [logic [31:0]];
    logic [31:0] adr_log [$];
    int          wait_states  = 0;
    int          wait_cnt     = 0;
    int          unstable_cnt = 0;
    logic [31:0] held_adr;
    int          wr_cycle, done_cycle, fault_cycle, wr_count;
    logic [1:0]  cause_seen;
    logic [15:0] tlbadr_seen;
    logic [63:0] tlbdat_seen;
    logic        ended;
    TLBEntry     exp_entry;
    int          busy_seen;
    int          late_events;

    task checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Bus slave: acks after wait_states idle strobe cycles, logs every acked address.
    always @(negedge clk) begin
        if (cyc_o && stb_o) begin
            if (wait_cnt == 0) held_adr = adr_o;
            else if (adr_o != held_adr) unstable_cnt++;
            if (wait_cnt >= wait_states) begin
                ack_i = 1'b1;
                dat_i = mem.exists(adr_o) ? mem[adr_o] : 64'h0;
                adr_log.push_back(adr_o);
                wait_cnt = 0;
            end else begin
                ack_i = 1'b0;
                dat_i = 64'h0;
                wait_cnt++;
            end
        end else begin
            ack_i    = 1'b0;
            dat_i    = 64'h0;
            wait_cnt = 0;
        end
    end

    // One walk: an idle cycle with miss low (optionally flushing), then accept at
    // edge 0 and record the cycle numbers of wrtlb/done/fault.
    task applyStimulus(input logic [31:0] va, input int waits, input bit hold, input bit do_flush);
        @(negedge clk);
        miss_i      = 1'b0;
        flush_i     = do_flush;
        wait_states = waits;
        @(negedge clk);
        flush_i      = 1'b0;
        miss_i       = 1'b1;
        miss_adr_i   = va;
        wr_cycle     = -1;
        done_cycle   = -1;
        fault_cycle  = -1;
        wr_count     = 0;
        cause_seen   = 2'd0;
        tlbadr_seen  = 16'h0;
        tlbdat_seen  = 64'h0;
        ended        = 1'b0;
        unstable_cnt = 0;
        adr_log.delete();
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!hold) miss_i = 1'b0;
            if (wrtlb_o) begin
                wr_count++;
                if (wr_cycle < 0) begin
                    wr_cycle    = c;
                    tlbadr_seen = tlbadr_o;
                    tlbdat_seen = tlbdat_o;
                end
            end
            if (done_o) done_cycle = c;
            if (fault_o) begin
                fault_cycle = c;
                cause_seen  = fault_cause_o;
            end
            if (done_o || fault_o) begin
                ended = 1'b1;
                break;
            end
        end
        checkOutput("walk_ended", ended, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_i      = 1'b1;
        miss_i     = 1'b0;
        miss_adr_i = 32'h0;
        asid_i     = 8'h5A;
        ptbr_i     = 32'h0010_0000;
        flush_i    = 1'b0;
        ack_i      = 1'b0;
        dat_i      = 64'h0;

        mem[32'h0010_0008] = 64'h0000_0000_0020_0001;
        mem[32'h0020_0018] = 64'h0000_0000_1234_51FF;
        mem[32'h0010_0010] = 64'h0000_0000_0020_0000;
        mem[32'h0010_0018] = 64'h0000_0000_0020_000B;
        mem[32'h0010_0020] = 64'h0000_0000_0030_0001;
        mem[32'h0030_0018] = 64'h0000_0000_1234_5000;
        mem[32'h0020_0028] = 64'h0000_0000_ABCD_E0C3;

        repeat (3) @(negedge clk);
        checkOutput("rst_ctrl", {busy_o, cyc_o, stb_o, wrtlb_o, done_o, fault_o, fault_cause_o}, 0);
        checkOutput("rst_adr", {adr_o, tlbadr_o}, 0);
        checkOutput("rst_tlbdat", tlbdat_o, 0);
        rst_i = 1'b0;

        $display("[TB] basic walk");
        applyStimulus(32'h0040_3ABC, 0, 1'b0, 1'b1);
        exp_entry      = '0;
        exp_entry.asid = 8'h5A;
        exp_entry.vpn  = 10'h001;
        exp_entry.ppn  = 20'h12345;
        {exp_entry.g, exp_entry.d, exp_entry.a, exp_entry.u,
         exp_entry.c, exp_entry.r, exp_entry.w, exp_entry.x} = 8'hFF;
        checkOutput("t1_nreads", adr_log.size(), 2);
        checkOutput("t1_l1adr", (adr_log.size() > 0) ? adr_log[0] : 32'hFFFF_FFFF, 32'h0010_0008);
        checkOutput("t1_l2adr", (adr_log.size() > 1) ? adr_log[1] : 32'hFFFF_FFFF, 32'h0020_0018);
        checkOutput("t1_wr_cycle", wr_cycle, 3);
        checkOutput("t1_done_cycle", done_cycle, 4);
        checkOutput("t1_wr_count", wr_count, 1);
        checkOutput("t1_tlbadr", tlbadr_seen, 16'h8003);
        checkOutput("t1_tlbdat", tlbdat_seen, exp_entry);
        checkOutput("t1_nofault", fault_cycle, -1);

        $display("[TB] L1 invalid");
        applyStimulus(32'h0080_3000, 0, 1'b0, 1'b1);
        checkOutput("t2_fault_cycle", fault_cycle, 2);
        checkOutput("t2_cause", cause_seen, 1);
        checkOutput("t2_wr_count", wr_count, 0);
        checkOutput("t2_nreads", adr_log.size(), 1);

        $display("[TB] L1 leaf");
        applyStimulus(32'h00C0_3000, 0, 1'b0, 1'b1);
        checkOutput("t3a_fault_cycle", fault_cycle, 2);
        checkOutput("t3a_cause", cause_seen, 3);
        checkOutput("t3a_wr_count", wr_count, 0);

        $display("[TB] L2 invalid");
        applyStimulus(32'h0100_3000, 0, 1'b0, 1'b1);
        checkOutput("t3b_fault_cycle", fault_cycle, 3);
        checkOutput("t3b_cause", cause_seen, 2);
        checkOutput("t3b_l2adr", (adr_log.size() > 1) ? adr_log[1] : 32'hFFFF_FFFF, 32'h0030_0018);
        checkOutput("t3b_wr_count", wr_count, 0);

        $display("[TB] wait states");
        applyStimulus(32'h0040_3ABC, 3, 1'b0, 1'b1);
        checkOutput("t4_wr_cycle", wr_cycle, 9);
        checkOutput("t4_done_cycle", done_cycle, 10);
        checkOutput("t4_stable", unstable_cnt, 0);
        checkOutput("t4_nreads", adr_log.size(), 2);

        $display("[TB] held miss");
        applyStimulus(32'h0040_3ABC, 0, 1'b1, 1'b1);
        checkOutput("t5_done_cycle", done_cycle, 4);
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy_o) busy_seen++;
        end
        checkOutput("t5_no_rewalk", busy_seen, 0);
        applyStimulus(32'h0040_3ABC, 0, 1'b0, 1'b1);
        checkOutput("t5_rewalk_done", done_cycle, 4);

`ifdef THOR2021_PTW_L1CACHE_EN
        $display("[TB] L1 cache hit");
        applyStimulus(32'h0040_5000, 0, 1'b0, 1'b0);
        checkOutput("c_hit_nreads", adr_log.size(), 1);
        checkOutput("c_hit_adr", (adr_log.size() > 0) ? adr_log[0] : 32'hFFFF_FFFF, 32'h0020_0028);
        checkOutput("c_hit_done", done_cycle, 3);
        applyStimulus(32'h0040_5000, 0, 1'b0, 1'b1);
        checkOutput("c_flush_nreads", adr_log.size(), 2);
        checkOutput("c_flush_l1adr", (adr_log.size() > 0) ? adr_log[0] : 32'hFFFF_FFFF, 32'h0010_0008);
        checkOutput("c_flush_done", done_cycle, 4);
`endif

        $display("[TB] reset during L2");
        wait_states = 0;
        @(negedge clk);
        miss_i = 1'b0;
        @(negedge clk);
        miss_i     = 1'b1;
        miss_adr_i = 32'h0040_3ABC;
        @(posedge clk);
        @(negedge clk);
        miss_i = 1'b0;
        @(negedge clk);
        checkOutput("t6_in_l2", {cyc_o, adr_o}, {1'b1, 32'h0020_0018});
        rst_i = 1'b1;
        @(negedge clk);
        checkOutput("t6_cyc_drop", {cyc_o, stb_o, busy_o}, 0);
        rst_i = 1'b0;
        late_events = 0;
        repeat (6) begin
            @(negedge clk);
            if (wrtlb_o || done_o || fault_o) late_events++;
        end
        checkOutput("t6_no_events", late_events, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/thor2021_ptw.md
Name: thor2021_ptw

Overview:
- Hardware page-table walker; it is the writer side of the TLB's miss/update interface.
- On a TLB miss it fetches a two-level page table (4 kB pages, 32-bit VA) over a read-only bus master port.
- It formats a TLBEntry and writes it into the TLB through the wrtlb/tlbadr/tlbdat port.
- On an invalid translation it raises a fault to the core instead.

Parameters:
- AWID, 32, virtual/physical address width. Only 32 is supported.
- ASIDW, 8, ASID width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- miss_i  in  1  TLB miss request (level)
- miss_adr_i  in  32  faulting virtual address
- asid_i  in  8  current ASID
- ptbr_i  in  32  page-table base; bits [12:0] ignored
- flush_i  in  1  invalidate walker-internal state
- busy_o  out  1  walk in progress
- done_o  out  1  one-cycle pulse, TLB entry written
- fault_o  out  1  one-cycle pulse, translation fault
- fault_cause_o  out  2  1 = L1 invalid, 2 = L2 invalid, 3 = L1 leaf
- cyc_o  out  1  bus cycle
- stb_o  out  1  bus strobe
- ack_i  in  1  bus acknowledge, data valid
- adr_o  out  32  bus byte address, 8-byte aligned
- dat_i  in  64  bus read data
- wrtlb_o  out  1  TLB write strobe
- tlbadr_o  out  16  TLB write address
- tlbdat_o  out  64  TLB entry

Behaviour:
- Reset values: every output is 0. State is IDLE. rearm = 1.
- PTE format (64 bits):
  - V = [0], X = [1], W = [2], R = [3], C = [4], U = [5], A = [6], D = [7], G = [8].
  - ppn = [31:12]. Bits [63:32] are reserved.
- Page tables are 1024 x 8 B = 8 kB and 8 kB aligned.
- L1 address = {ptbr_i[31:13], va[31:22], 3'b000}.
- L2 address = {L1pte[31:13], va[21:12], 3'b000}.
- States: IDLE, L1, L2, WR, DONE, FAULT.
- IDLE:
  - Accepts a walk when miss_i && rearm.
  - Latches va = miss_adr_i and asid_i.
  - Clears rearm and goes to L1.
  - rearm is set again by any cycle with miss_i == 0 while in IDLE. This prevents re-walking a stale miss that the TLB has not yet dropped.
- L1:
  - cyc_o = stb_o = 1, adr_o = L1 address. Hold until ack_i.
  - On ack_i, latch dat_i and drop cyc/stb the same cycle.
  - V == 0 -> FAULT, cause 1.
  - Any of R/W/X set -> FAULT, cause 3 (superpages are unsupported).
  - Otherwise -> L2.
- L2:
  - Same handshake at the L2 address.
  - V == 0 -> FAULT, cause 2. Otherwise latch the PTE and go to WR.
- WR:
  - wrtlb_o = 1 for exactly one cycle.
  - tlbadr_o = {1'b1, 3'b000, 2'b00, va[21:12]}. Bit 15 selects the TLB random way.
  - tlbdat_o is a TLBEntry with: vpn = va[31:22], ppn = PTE[31:12], ASID = latched asid, and G/D/A/U/C/R/W/X copied from the PTE.
  - Next state DONE.
- DONE: done_o = 1 for one cycle, then IDLE.
- FAULT: fault_o = 1 and fault_cause_o valid for one cycle, then IDLE. No TLB write occurs.
- busy_o = 1 in every state except IDLE.
- Latency with zero-wait ack (ack_i asserted in the first stb cycle): accept at edge 0; L1 in cycle 1, L2 in cycle 2, wrtlb_o in cycle 3, done_o in cycle 4.
- Wait states stretch L1 and L2 without limit. stb_o and adr_o stay stable until ack_i.
- ack_i outside L1/L2 is ignored.
- flush_i:
  - In IDLE it only clears optional-feature state.
  - During a walk it does not abort the walk.
- rst_i mid-walk: cyc_o and stb_o drop on the next edge. No wrtlb_o, done_o or fault_o is produced.
- miss_i falling mid-walk: the walk still completes. This is harmless because the TLB write is idempotent.

Optional Feature:
- Macro: THOR2021_PTW_L1CACHE_EN.
- When defined, the walker has a one-entry cache holding {valid, ptbr[31:13], va[31:22], L1pte}.
  - On a hit, IDLE goes directly to L2, saving one bus access. done_o then comes in cycle 3.
  - The cache is filled on every successful L1 access.
  - It is invalidated by rst_i, flush_i, or any change of ptbr_i.
- When undefined, every walk performs both accesses and the cache logic is absent.

Decomposition:
- Thor2021_pkg holds:
  - the existing TLBEntry;
  - new typedef PTE (packed fields as above);
  - enum ptw_state_t;
  - localparams PTW_FC_L1INV = 1, PTW_FC_L2INV = 2, PTW_FC_L1LEAF = 3.
- Natural sub-module: thor2021_ptw_l1cache, instantiated only under the macro.

Test Plan:
1. ptbr = 0x0010_0000, va = 0x0040_3ABC, L1pte = 0x0020_0001, L2pte = 0x1234_51FF.
   - Expect reads at 0x0010_0008 then 0x0020_0018.
   - Expect wrtlb_o in cycle 3, tlbadr_o = 0x8003, tlbdat_o.ppn = 0x12345, vpn = 0x001, all flags set.
   - Expect done_o in cycle 4.
2. L1pte V = 0 -> fault_o with cause 1. No wrtlb_o. Only one bus cycle.
3. L1pte = 0x0020_000B (leaf) -> cause 3. L2pte V = 0 -> cause 2.
4. Insert 3 wait states per ack -> done_o in cycle 10. stb_o and adr_o remain stable throughout.
5. Hold miss_i high after done_o -> no second walk until miss_i has been low for one cycle.
6. Assert rst_i in L2 -> cyc_o = 0 next cycle, no done_o.
   - With the macro defined: a second miss in the same 4 MB region skips the L1 read.
   - After flush_i, the L1 read returns.
